// File: rtl/gerador_reset_entrada.sv
// gerador_reset_entrada
// Multi-channel generator of the active-low input-clear signals for the Sudoku
// input path. Each board key is synchronised, debounced and gated with the
// current game state through ALLOW_MASK. In pulse mode an accepted press gives
// one PULSE_CYCLES-long clear. In level mode the clear follows the held key
// while the game state permits it.
//
// Per channel the pulse FSM state is held in g_canal[i].estado, and its pulse
// counter in g_canal[i].cont_pulso.
module gerador_reset_entrada #(
    parameter int                      NUM_KEYS        = 2,
    parameter int                      STATE_W         = 3,
    parameter logic [2**STATE_W-1:0]   ALLOW_MASK      = 8'b0000_1111,
    parameter int                      DEBOUNCE_CYCLES = 4,
    parameter int                      PULSE_CYCLES    = 3,
    parameter int                      LEVEL_MODE      = 0
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [NUM_KEYS-1:0] keyReset,
    input  logic [STATE_W-1:0]  estadoJogo,
    output logic [NUM_KEYS-1:0] saidaResetEntrada,
    output logic                saidaResetGeral,
    output logic [NUM_KEYS-1:0] eventoAceito
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    // Last counter value before the debounced level may change / pulse ends.
    localparam logic [CNT_W-1:0]  DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        PULSO         = 2'd1,
        ESPERA_SOLTAR = 2'd2
    } estado_pulso_t;

    // Permission for the current game state. The full STATE_W bits index the mask.
    logic permitido;
    assign permitido = ALLOW_MASK[estadoJogo];

    genvar i;
    generate
        for (i = 0; i < NUM_KEYS; i++) begin : g_canal
            logic              sinc1;
            logic              sinc2;
            logic [CNT_W-1:0]  cont_deb;
            logic              nivel_deb;
            logic              nivel_deb_ant;
            logic              queda;
            estado_pulso_t     estado;
            logic [PCNT_W-1:0] cont_pulso;
            logic              saida_q;
            logic              evento_q;

            // Debounced level went 1 -> 0 on the previous edge: a candidate press.
            assign queda = nivel_deb_ant & ~nivel_deb;

            // Two-flop synchroniser for the asynchronous key; released level is 1.
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    sinc1 <= 1'b1;
                    sinc2 <= 1'b1;
                end else begin
                    sinc1 <= keyReset[i];
                    sinc2 <= sinc1;
                end
            end

            // Debouncer: the level only changes after DEBOUNCE_CYCLES consecutive
            // disagreeing cycles, and any agreeing cycle restarts the count.
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    cont_deb      <= '0;
                    nivel_deb     <= 1'b1;
                    nivel_deb_ant <= 1'b1;
                end else begin
                    nivel_deb_ant <= nivel_deb;
                    if (sinc2 != nivel_deb) begin
                        if (cont_deb == DEB_LAST) begin
                            nivel_deb <= sinc2;
                            cont_deb  <= '0;
                        end else begin
                            cont_deb <= cont_deb + 1'b1;
                        end
                    end else begin
                        cont_deb <= '0;
                    end
                end
            end

            // Output logic: pulse FSM or level follower, plus the acceptance strobe.
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    estado     <= OCIOSO;
                    cont_pulso <= '0;
                    saida_q    <= 1'b1;
                    evento_q   <= 1'b0;
                end else begin
                    evento_q <= 1'b0;
                    if (LEVEL_MODE != 0) begin
                        // The FSM is parked in level mode.
                        estado     <= OCIOSO;
                        cont_pulso <= '0;
                        saida_q    <= ~(~nivel_deb & permitido);
                        evento_q   <= queda & permitido;
                    end else begin
                        case (estado)
                            OCIOSO: begin
                                // The permission is taken once, at acceptance. Later
                                // state changes do not shorten the pulse.
                                if (queda && permitido) begin
                                    estado     <= PULSO;
                                    cont_pulso <= '0;
                                    saida_q    <= 1'b0;
                                    evento_q   <= 1'b1;
                                end
                            end
                            PULSO: begin
                                if (cont_pulso == PULSE_LAST) begin
                                    cont_pulso <= '0;
                                    saida_q    <= 1'b1;
                                    estado     <= nivel_deb ? OCIOSO : ESPERA_SOLTAR;
                                end else begin
                                    cont_pulso <= cont_pulso + 1'b1;
                                end
                            end
                            ESPERA_SOLTAR: begin
                                // A held key gives exactly one pulse. Re-arm only after release.
                                if (nivel_deb) begin
                                    estado <= OCIOSO;
                                end
                            end
                            default: begin
                                estado     <= OCIOSO;
                                cont_pulso <= '0;
                                saida_q    <= 1'b1;
                            end
                        endcase
                    end
                end
            end

            assign saidaResetEntrada[i] = saida_q;
            assign eventoAceito[i]      = evento_q;
        end
    endgenerate

    // Global clear: low whenever any channel was clearing on the previous cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            saidaResetGeral <= 1'b1;
        end else begin
            saidaResetGeral <= &saidaResetEntrada;
        end
    end

endmodule

// File: tb/tb_gerador_reset_entrada.sv
// tb_gerador_reset_entrada
// Two instances share the same keys and game state: one in pulse mode and one
// in level mode. A behavioural model pushes the expected output vector for each
// clock edge into exp_q. A monitor pops the queue and compares after every edge.
module tb_gerador_reset_entrada;

    localparam int NK   = 2;
    localparam int SW   = 3;
    localparam int D    = 4;
    localparam int P    = 3;
    localparam int W    = 10;
    localparam int HMAX = 8192;
    localparam logic [7:0] MASK = 8'h0F;

    // Expected vector while in reset: all clears high, no strobes.
    localparam logic [W-1:0] RST_EXP = {1'b1, 2'b00, 2'b11, 1'b1, 2'b00, 2'b11};

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic [NK-1:0] keyReset = '1;
    logic [SW-1:0] estadoJogo = '0;

    logic [NK-1:0] p_saida, p_ev, l_saida, l_ev;
    logic          p_geral, l_geral;

    gerador_reset_entrada #(
        .NUM_KEYS(NK), .STATE_W(SW), .ALLOW_MASK(MASK),
        .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .LEVEL_MODE(0)
    ) dut_pulso (
        .clk(clk), .resetN(resetN), .keyReset(keyReset), .estadoJogo(estadoJogo),
        .saidaResetEntrada(p_saida), .saidaResetGeral(p_geral), .eventoAceito(p_ev)
    );

    gerador_reset_entrada #(
        .NUM_KEYS(NK), .STATE_W(SW), .ALLOW_MASK(MASK),
        .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .LEVEL_MODE(1)
    ) dut_nivel (
        .clk(clk), .resetN(resetN), .keyReset(keyReset), .estadoJogo(estadoJogo),
        .saidaResetEntrada(l_saida), .saidaResetGeral(l_geral), .eventoAceito(l_ev)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] observed();
        return {l_geral, l_ev, l_saida, p_geral, p_ev, p_saida};
    endfunction

    task automatic check_now(input string name, input logic [W-1:0] exp);
        logic [W-1:0] act;
        act = observed();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Edges are numbered from 1 after each reset release. Index 0 holds reset values.
    int   n;
    logic key_h [NK][HMAX];
    logic syn_h [NK][HMAX];
    logic deb_h [NK][HMAX];
    int   last_flip [NK];
    int   last_acc  [NK];
    logic [NK-1:0] p_out_prev;
    logic [NK-1:0] l_out_prev;

    task automatic model_reset();
        n = 0;
        for (int c = 0; c < NK; c++) begin
            key_h[c][0]  = 1'b1;
            syn_h[c][0]  = 1'b1;
            deb_h[c][0]  = 1'b1;
            last_flip[c] = 0;
            last_acc[c]  = -1000;
        end
        p_out_prev = '1;
        l_out_prev = '1;
    endtask

    // Computes the outputs expected after the edge that samples (k, st).
    task automatic model_step(input logic [NK-1:0] k, input logic [SW-1:0] st);
        logic [7:0]    mask_v;
        logic [NK-1:0] p_out, p_evx, l_out, l_evx;
        logic          ok, fell, stable;
        mask_v = MASK;
        n++;
        if (n >= HMAX) begin
            $display("FAIL model_history: actual=%0d required<%0d", n, HMAX);
            $fatal(1, "model history exhausted");
        end
        ok = mask_v[st];
        for (int c = 0; c < NK; c++) begin
            key_h[c][n] = k[c];
            // The synchronised key lags the sampled key by one edge.
            syn_h[c][n] = key_h[c][n-1];
            // The level changes once the synchronised key has disagreed with it
            // for the last D cycles, counted from the previous change.
            deb_h[c][n] = deb_h[c][n-1];
            if (n - last_flip[c] >= D) begin
                stable = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (syn_h[c][n-j] == deb_h[c][n-1]) stable = 1'b0;
                if (stable) begin
                    deb_h[c][n]  = ~deb_h[c][n-1];
                    last_flip[c] = n;
                end
            end
            fell = (n >= 2) && deb_h[c][n-2] && !deb_h[c][n-1];
            // Pulse mode: accept only when the previous pulse has fully ended.
            p_evx[c] = fell && ok && (n >= last_acc[c] + P + 1);
            if (p_evx[c]) last_acc[c] = n;
            p_out[c] = !((n >= last_acc[c]) && (n <= last_acc[c] + P - 1));
            // Level mode: follow the held key gated by the current state.
            l_evx[c] = fell && ok;
            l_out[c] = !(!deb_h[c][n-1] && ok);
        end
        exp_q.push_back({&l_out_prev, l_evx, l_out, &p_out_prev, p_evx, p_out});
        p_out_prev = p_out;
        l_out_prev = l_out;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic [NK-1:0] k, input logic [SW-1:0] s, input bit do_release);
        @(negedge clk);
        if (do_release) begin
            resetN = 1'b1;
            model_reset();
        end
        keyReset   = k;
        estadoJogo = s;
        if (resetN) model_step(k, s);
    endtask

    task automatic hold(input logic [NK-1:0] k, input logic [SW-1:0] s, input int cyc);
        for (int i = 0; i < cyc; i++) drive_cycle(k, s, 1'b0);
    endtask

    task automatic random_phase(input int runs);
        logic [NK-1:0] k;
        logic [SW-1:0] s;
        int len;
        for (int r = 0; r < runs; r++) begin
            k   = NK'($urandom_range(0, 3));
            s   = SW'($urandom_range(0, 7));
            len = int'($urandom_range(1, 12));
            hold(k, s, len);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check_now("edge_outputs", exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        resetN     = 1'b0;
        keyReset   = 2'b00;
        estadoJogo = 3'd0;
        repeat (3) @(negedge clk);
        check_now("reset_hold", RST_EXP);

        // Release with both keys held: the first clear appears D+3 edges later.
        drive_cycle(2'b00, 3'd0, 1'b1);
        hold(2'b00, 3'd0, 14);
        hold(2'b11, 3'd0, 15);

        // Clean 20-cycle press in a permitted state.
        hold(2'b10, 3'd1, 20);
        hold(2'b11, 3'd1, 15);

        // Three-cycle glitch: rejected.
        hold(2'b10, 3'd1, 3);
        hold(2'b11, 3'd1, 15);

        // Forbidden state, which then becomes permitted while the key is still held.
        hold(2'b10, 3'd4, 20);
        hold(2'b10, 3'd0, 10);
        hold(2'b11, 3'd0, 15);

        // Accept in state 3, leave the permitted set one cycle later, and bounce the key mid-pulse.
        hold(2'b10, 3'd3, D + 4);
        hold(2'b10, 3'd5, 1);
        hold(2'b11, 3'd5, 1);
        hold(2'b10, 3'd5, 12);
        hold(2'b11, 3'd0, 15);

        // Both keys pressed in state 2, then the state moves to forbidden state 4.
        hold(2'b00, 3'd2, 20);
        hold(2'b00, 3'd4, 5);
        hold(2'b11, 3'd4, 15);

        // Randomised key and state activity.
        random_phase(200);
        hold(2'b11, 3'd0, 15);

        // Asynchronous reset in the middle of a press.
        hold(2'b00, 3'd2, 9);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check_now("async_reset", RST_EXP);
        drive_cycle(2'b00, 3'd2, 1'b0);
        drive_cycle(2'b00, 3'd2, 1'b0);
        #1;
        check_now("reset_held_press", RST_EXP);

        drive_cycle(2'b11, 3'd0, 1'b1);
        random_phase(40);
        hold(2'b11, 3'd0, 20);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: actual=%0d pending required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gerador_reset_entrada.md
# gerador_reset_entrada

Parametrised, multi-channel generator of the input-clear signals for the Sudoku input path. It takes NUM_KEYS active-low board keys, synchronises and debounces each one, and gates it with the current game state through a per-state permission mask. In pulse mode it emits one fixed-length active-low clear per accepted press; in level mode it holds the clear low while the key is held in a permitted state. It sits between the board keys and the row/column/value input registers and is driven by the main game FSM's state bus.

## Interface
- NUM_KEYS, 2: number of independent key/clear channels (≥1).
- STATE_W, 3: width of estadoJogo.
- ALLOW_MASK, 8'b0000_1111: 2^STATE_W bits; bit i = 1 means a clear is permitted in game state i. The default permits recebeLinha, recebeColuna, verificaPos and recebeValor (0–3).
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a key change (≥1).
- PULSE_CYCLES, 3: clear pulse length in pulse mode (≥1).
- LEVEL_MODE, 0: 0 = pulse mode, 1 = level mode.
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- keyReset  input  NUM_KEYS  raw board keys, active-low (0 = pressed), asynchronous to clk.
- estadoJogo  input  STATE_W  current game FSM state, synchronous to clk.
- saidaResetEntrada  output  NUM_KEYS  per-channel clear, active-low, registered.
- saidaResetGeral  output  1  AND of all saidaResetEntrada bits (low if any channel is clearing), registered.
- eventoAceito  output  NUM_KEYS  one-cycle high strobe per accepted press, registered.

## Operation
- **Per-channel pipeline**
  - 2-flop synchroniser.
  - Debouncer: a counter of width $clog2(DEBOUNCE_CYCLES+1) plus a debounced level.
  - Press detector.
  - Output logic.
- **Debounce**
  - While the synchronised key differs from the debounced level, the counter increments.
  - When the counter has seen DEBOUNCE_CYCLES consecutive mismatching cycles, the debounced level takes the new value and the counter clears.
  - Any matching cycle clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- **Press acceptance:** a press is accepted on the cycle the debounced level goes 1→0 AND ALLOW_MASK[estadoJogo] = 1, with estadoJogo sampled on that cycle.
- **Pulse mode FSM (per channel)**
  - States:
    - OCIOSO: output high.
    - PULSO: output low, count 0..PULSE_CYCLES-1.
    - ESPERA_SOLTAR: output high, waiting for the debounced key to return to 1.
  - OCIOSO→PULSO on an accepted press.
  - PULSO→ESPERA_SOLTAR after PULSE_CYCLES cycles.
  - ESPERA_SOLTAR→OCIOSO when the debounced level is 1.
  - If the key is already released when the pulse ends, go directly to OCIOSO.
- **Level mode:** saidaResetEntrada[i] = !(debounced pressed && ALLOW_MASK[estadoJogo]), registered. The pulse FSM is unused and its counter is held at 0.
- **eventoAceito[i]:** pulses high for one cycle on every accepted press, in both modes.
- **Boundary conditions**
  - Key held indefinitely: exactly one pulse (pulse mode).
  - New press during PULSO or ESPERA_SOLTAR: ignored, no retrigger, no eventoAceito.
  - estadoJogo leaves the permitted set mid-pulse: the pulse completes at full length (the decision is latched at acceptance).
  - estadoJogo leaves the permitted set in level mode: output returns high on the next edge.
  - Press in a forbidden state that becomes permitted while the key is still held: not accepted in pulse mode; asserts on the next edge in level mode.
  - Simultaneous presses on several channels are independent; saidaResetGeral reflects any of them.
  - States ≥ 2^STATE_W cannot occur; mask indexing uses the full STATE_W bits.

## Timing
- Reset (resetN = 0, asynchronous):
  - saidaResetEntrada = all 1, saidaResetGeral = 1, eventoAceito = all 0.
  - Synchronisers reset to 1, debounced levels reset to 1, counters to 0, FSM to OCIOSO.
- Release of resetN is taken synchronously at the next clk edge.
- Latency, with edge 1 = first edge sampling keyReset low and D = DEBOUNCE_CYCLES:
  - Synchronised value low after edge 2.
  - Debounced level low after edge D+2.
  - saidaResetEntrada and eventoAceito change after edge D+3.
  - saidaResetGeral changes after edge D+4.
- Pulse width is exactly PULSE_CYCLES cycles, i.e. low after edges D+3 through D+2+PULSE_CYCLES.
- Release latency is symmetric: D+2 edges to the debounced level returning to 1.
- Reset asserted mid-pulse: outputs go high immediately, without waiting for clk.

## Test plan
- Test configuration: NUM_KEYS=2, D=4, P=3, mask 8'h0F.
- Reset: hold resetN=0 with keyReset=2'b00 → saidaResetEntrada=2'b11, saidaResetGeral=1, eventoAceito=0. Release → no pulse until D+3 edges after release.
- Clean press in state 3'b001:
  - Key0 low for 20 cycles → saidaResetEntrada[0] low for exactly 3 cycles starting after edge 7.
  - eventoAceito[0] high for 1 cycle after edge 7.
  - saidaResetGeral low for 3 cycles starting after edge 8.
  - Only one pulse while the key is held.
- Glitch rejection: key0 low for 3 cycles, then high → no pulse, no eventoAceito.
- Forbidden state: estadoJogo=3'b100 (verificaJogo) with a 20-cycle press → outputs stay 1. Then switching to 3'b000 while still held → still no pulse.
- State change mid-pulse: accept in 3'b011, switch to 3'b101 one cycle later → pulse still 3 cycles. Second press during the pulse → ignored.
- Level mode, with resetN dropped mid-press:
  - Set LEVEL_MODE=1 and press both keys in state 3'b010 → both outputs low from edge 7 until the state changes to 3'b100, high on the next edge.
  - Assert resetN=0 during a press → outputs 1 asynchronously.
